// File: rtl/maxpool_reader_if.sv
// Handshake and data bundle between a conv stage (master) and the max-pool reader (slave).
// The feature map and pooled result travel as signed 2-D arrays.
interface maxpool_reader_if #(
  parameter int SIZE      = 5,
  parameter int POOL      = 2,
  parameter int WIDTH_BIT = 8
);
  localparam int OSIZE = SIZE / POOL;

  logic                        start;
  logic signed [WIDTH_BIT-1:0] inpMatrixI [SIZE-1:0][SIZE-1:0];
  logic                        busy;
  logic                        done;
  logic signed [WIDTH_BIT-1:0] poolOut [OSIZE-1:0][OSIZE-1:0];

  modport master (output start, inpMatrixI, input busy, done, poolOut);
  modport slave  (input start, inpMatrixI, output busy, done, poolOut);
endinterface

// File: rtl/maxpool_reader.sv
// Non-overlapping POOL x POOL signed max-pooling over a finished SIZE x SIZE feature map,
// one element compared per cycle, windows scanned row-major into a registered output matrix.
module maxpool_reader #(
  parameter int SIZE      = 5,
  parameter int POOL      = 2,
  parameter int WIDTH_BIT = 8
) (
  input logic              clock,
  input logic              nreset,
  maxpool_reader_if.slave  bus
);
  localparam int OSIZE = SIZE / POOL;
  localparam int OW    = (OSIZE > 1) ? $clog2(OSIZE) : 1;
  localparam int PW    = (POOL > 1) ? $clog2(POOL) : 1;
  localparam int SW    = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [OW-1:0] OLAST = OW'(OSIZE - 1);
  localparam logic [PW-1:0] PLAST = PW'(POOL - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CMP   = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                      state_q, state_d;
  logic [OW-1:0]               i_q, i_d, j_q, j_d;
  logic [PW-1:0]               wr_q, wr_d, wc_q, wc_d;
  logic signed [WIDTH_BIT-1:0] acc_q, acc_d;
  logic                        busy_q, busy_d, done_q, done_d;
  logic signed [WIDTH_BIT-1:0] win_q [POOL-1:0][POOL-1:0];
  logic signed [WIDTH_BIT-1:0] pool_q [OSIZE-1:0][OSIZE-1:0];
  logic signed [WIDTH_BIT-1:0] elem_s;

  assign elem_s       = win_q[wr_q][wc_q];
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.poolOut  = pool_q;

  // Next-state, counter and accumulator logic
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    wr_d    = wr_q;
    wc_d    = wc_q;
    acc_d   = acc_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          i_d     = '0;
          j_d     = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        state_d = S_CMP;
        wr_d    = '0;
        wc_d    = '0;
      end
      S_CMP: begin
        // Strict greater-than keeps the earlier element on ties
        if ((wr_q == '0) && (wc_q == '0)) begin
          acc_d = elem_s;
        end else if (elem_s > acc_q) begin
          acc_d = elem_s;
        end else begin
          acc_d = acc_q;
        end
        if ((wr_q == PLAST) && (wc_q == PLAST)) begin
          state_d = S_WRITE;
          wr_d    = '0;
          wc_d    = '0;
        end else if (wc_q == PLAST) begin
          wc_d = '0;
          wr_d = wr_q + PW'(1);
        end else begin
          wc_d = wc_q + PW'(1);
        end
      end
      S_WRITE: begin
        if (j_q != OLAST) begin
          j_d     = j_q + OW'(1);
          state_d = S_LOAD;
        end else if (i_q != OLAST) begin
          j_d     = '0;
          i_d     = i_q + OW'(1);
          state_d = S_LOAD;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State, counters, accumulator and registered status outputs
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      wr_q    <= '0;
      wc_q    <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      wr_q    <= wr_d;
      wc_q    <= wc_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Window capture in LOAD and pooled-result write in WRITE
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      for (int r = 0; r < POOL; r++) begin
        for (int c = 0; c < POOL; c++) begin
          win_q[r][c] <= '0;
        end
      end
      for (int r = 0; r < OSIZE; r++) begin
        for (int c = 0; c < OSIZE; c++) begin
          pool_q[r][c] <= '0;
        end
      end
    end else begin
      if (state_q == S_LOAD) begin
        for (int r = 0; r < POOL; r++) begin
          for (int c = 0; c < POOL; c++) begin
            win_q[r][c] <= bus.inpMatrixI[SW'(int'(i_q) * POOL + r)][SW'(int'(j_q) * POOL + c)];
          end
        end
      end
      if (state_q == S_WRITE) begin
        pool_q[i_q][j_q] <= acc_q;
      end
    end
  end
endmodule

// File: tb/tb_maxpool_reader.sv
// Scoreboard bench: a 5x5 and a 4x4 instance; stimulus pushes expected pooled matrices and
// done cycles, a negedge monitor pops and compares whenever done is seen.
module tb_maxpool_reader;
  logic clock;
  logic nreset;
  int   cyc;
  int   n_checks;
  int   n_pass;

  logic [31:0] exp5_q[$];
  int          cyc5_q[$];
  logic [31:0] exp4_q[$];
  int          cyc4_q[$];

  maxpool_reader_if #(.SIZE(5), .POOL(2), .WIDTH_BIT(8)) if5();
  maxpool_reader_if #(.SIZE(4), .POOL(2), .WIDTH_BIT(8)) if4();

  maxpool_reader #(.SIZE(5), .POOL(2), .WIDTH_BIT(8)) u5 (
    .clock (clock),
    .nreset(nreset),
    .bus   (if5.slave)
  );
  maxpool_reader #(.SIZE(4), .POOL(2), .WIDTH_BIT(8)) u4 (
    .clock (clock),
    .nreset(nreset),
    .bus   (if4.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h expected %h", name, got, exp);
  endtask

  function automatic logic [31:0] pool5();
    return {if5.poolOut[0][0], if5.poolOut[0][1], if5.poolOut[1][0], if5.poolOut[1][1]};
  endfunction

  function automatic logic [31:0] pool4();
    return {if4.poolOut[0][0], if4.poolOut[0][1], if4.poolOut[1][0], if4.poolOut[1][1]};
  endfunction

  // Monitor: pop and compare on every done pulse
  always @(negedge clock) begin
    if (if5.done) begin
      if (exp5_q.size() == 0) begin
        check("u5_unexpected_done", 32'd1, 32'd0);
      end else begin
        check("u5_pool", pool5(), exp5_q.pop_front());
        check("u5_done_cycle", cyc, cyc5_q.pop_front());
        check("u5_busy_at_done", {31'd0, if5.busy}, 32'd1);
      end
    end
    if (if4.done) begin
      if (exp4_q.size() == 0) begin
        check("u4_unexpected_done", 32'd1, 32'd0);
      end else begin
        check("u4_pool", pool4(), exp4_q.pop_front());
        check("u4_done_cycle", cyc, cyc4_q.pop_front());
        check("u4_busy_at_done", {31'd0, if4.busy}, 32'd1);
      end
    end
  end

  task automatic set_ramp5();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        if5.inpMatrixI[r][c] = 8'(r * 5 + c);
  endtask

  // Each wXX packs one 2x2 window row-major, MSB byte first; row/col 4 get pad
  task automatic set_win5(input logic [31:0] w00, input logic [31:0] w01,
                          input logic [31:0] w10, input logic [31:0] w11,
                          input logic [7:0] pad);
    logic [31:0] w;
    int k;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        if (r == 4 || c == 4) begin
          if5.inpMatrixI[r][c] = pad;
        end else begin
          if (r < 2) w = (c < 2) ? w00 : w01;
          else       w = (c < 2) ? w10 : w11;
          k = (r % 2) * 2 + (c % 2);
          if5.inpMatrixI[r][c] = w[31 - 8 * k -: 8];
        end
      end
    end
  endtask

  task automatic start5(input logic [31:0] exp);
    exp5_q.push_back(exp);
    cyc5_q.push_back(cyc + 25);
    if5.start = 1'b1;
    @(negedge clock);
    if5.start = 1'b0;
  endtask

  task automatic wait_idle5(input string name);
    int t;
    t = 0;
    while ((if5.busy || if5.done) && t < 100) begin
      @(negedge clock);
      t++;
    end
    check(name, {31'd0, if5.busy}, 32'd0);
  endtask

  initial begin
    int t;
    n_checks    = 0;
    n_pass      = 0;
    cyc         = 0;
    nreset      = 1'b0;
    if5.start   = 1'b0;
    if4.start   = 1'b0;
    set_ramp5();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if4.inpMatrixI[r][c] = 8'(r * 4 + c + 1);
    repeat (2) @(negedge clock);
    check("rst_busy5", {31'd0, if5.busy}, 32'd0);
    check("rst_done5", {31'd0, if5.done}, 32'd0);
    check("rst_pool5", pool5(), 32'd0);
    check("rst_pool4", pool4(), 32'd0);
    nreset = 1'b1;
    @(negedge clock);

    // 4x4 ramp on the SIZE=4 instance
    exp4_q.push_back(32'h06080E10);
    cyc4_q.push_back(cyc + 25);
    if4.start = 1'b1;
    @(negedge clock);
    if4.start = 1'b0;
    repeat (10) @(negedge clock);
    check("u4_busy_mid", {31'd0, if4.busy}, 32'd1);

    // 5x5 ramp: row/col 4 (incl. 24) must not matter
    start5(32'h06081012);
    wait_idle5("ramp5_idle");

    // Signed windows
    set_win5(32'h80FDF99C, 32'h80FDF99C, 32'h80FDF99C, 32'h80FDF99C, 8'h7F);
    start5(32'hFDFDFDFD);
    wait_idle5("neg_idle");
    set_win5(32'h80808080, 32'h80808080, 32'h80808080, 32'h80808080, 8'h7F);
    start5(32'h80808080);
    wait_idle5("min_idle");

    // Ties, late max, mixed signs; start re-pulsed mid-job
    set_win5(32'h09090209, 32'h0000007F, 32'h80FDF99C, 32'h05FF0504, 8'h7F);
    start5(32'h097FFD05);
    repeat (2) @(negedge clock);
    if5.start = 1'b1;
    @(negedge clock);
    if5.start = 1'b0;
    repeat (6) @(negedge clock);
    if5.start = 1'b1;
    @(negedge clock);
    if5.start = 1'b0;
    t = 0;
    while (!if5.done && t < 100) begin
      @(negedge clock);
      t++;
    end
    check("restart_done_seen", {31'd0, if5.done}, 32'd1);
    // Back-to-back: start held from DONE into the following IDLE cycle
    set_ramp5();
    if5.start = 1'b1;
    @(negedge clock);
    exp5_q.push_back(32'h06081012);
    cyc5_q.push_back(cyc + 25);
    @(negedge clock);
    if5.start = 1'b0;
    wait_idle5("b2b_idle");

    // Reset at edge 12 of a job
    set_win5(32'h01020304, 32'h01020304, 32'h01020304, 32'h01020304, 8'h7F);
    start5(32'h04040404);
    repeat (12) @(posedge clock);
    #1 nreset = 1'b0;
    #1;
    check("midrst_busy", {31'd0, if5.busy}, 32'd0);
    check("midrst_done", {31'd0, if5.done}, 32'd0);
    check("midrst_pool", pool5(), 32'd0);
    void'(exp5_q.pop_back());
    void'(cyc5_q.pop_back());
    @(negedge clock);
    nreset = 1'b1;
    @(negedge clock);
    start5(32'h04040404);
    wait_idle5("after_rst_idle");

    repeat (5) @(negedge clock);
    check("drain5", exp5_q.size(), 32'd0);
    check("drain4", exp4_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
